// File: rtl/axis_slave_fifo.sv
// rtl/axis_slave_fifo.sv - first-word fall-through stream FIFO with optional dest/id/last fields
module axis_slave_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int HAS_DEST   = 0,
  parameter int HAS_ID     = 0,
  parameter int HAS_LAST   = 0,
  parameter int DEPTH      = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DEST_WIDTH-1:0]   s_dest,
  input  logic [ID_WIDTH-1:0]     s_id,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [DEST_WIDTH-1:0]   m_dest,
  output logic [ID_WIDTH-1:0]     m_id,
  output logic                    m_last,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // Write enable ignores areset on purpose: a write during reset only touches
  // storage, which is dead data once the pointers are cleared.
  assign wr_en   = s_valid && (state != FULL);
  assign rd_en   = (state != EMPTY) && m_ready;
  assign s_ready = !areset && (state != FULL);
  assign m_valid = (state != EMPTY);

  // Occupancy state register, pointers and count.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next occupancy state from push/pop and the current count.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (wr_en) state_next = PARTIAL;
      end
      PARTIAL: begin
        if (wr_en && !rd_en && (count == CW'(DEPTH - 1)))
          state_next = FULL;
        else if (rd_en && !wr_en && (count == CW'(1)))
          state_next = EMPTY;
      end
      FULL: begin
        if (rd_en) state_next = PARTIAL;
      end
      default: state_next = EMPTY;
    endcase
  end

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  // Payload storage, written at the tail and read combinationally at the head.
  always_ff @(posedge aclk) begin
    if (wr_en) data_mem[wr_ptr] <= s_data;
  end
  assign m_data = data_mem[rd_ptr];

  generate
    if (HAS_DEST != 0) begin : g_dest
      logic [DEST_WIDTH-1:0] dest_mem [DEPTH];
      // Routing tag storage, aligned with the payload entry.
      always_ff @(posedge aclk) begin
        if (wr_en) dest_mem[wr_ptr] <= s_dest;
      end
      assign m_dest = dest_mem[rd_ptr];
    end else begin : g_no_dest
      logic unused_dest;
      assign unused_dest = ^s_dest;
      assign m_dest = '0;
    end

    if (HAS_ID != 0) begin : g_id
      logic [ID_WIDTH-1:0] id_mem [DEPTH];
      // Source tag storage, aligned with the payload entry.
      always_ff @(posedge aclk) begin
        if (wr_en) id_mem[wr_ptr] <= s_id;
      end
      assign m_id = id_mem[rd_ptr];
    end else begin : g_no_id
      logic unused_id;
      assign unused_id = ^s_id;
      assign m_id = '0;
    end

    if (HAS_LAST != 0) begin : g_last
      logic last_mem [DEPTH];
      // End-of-packet flag storage, aligned with the payload entry.
      always_ff @(posedge aclk) begin
        if (wr_en) last_mem[wr_ptr] <= s_last;
      end
      assign m_last = last_mem[rd_ptr];
    end else begin : g_no_last
      logic unused_last;
      assign unused_last = s_last;
      assign m_last = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_axis_slave_fifo.sv
// tb/tb_axis_slave_fifo.sv - randomized and directed self-checking bench for axis_slave_fifo
module tb_axis_slave_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [1:0]    s_dest;
  logic [1:0]    s_id;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    m_dest;
  logic [1:0]    m_id;
  logic          m_last;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  axis_slave_fifo #(
    .DATA_WIDTH(DW), .DEST_WIDTH(2), .ID_WIDTH(2),
    .HAS_DEST(1), .HAS_ID(0), .HAS_LAST(1), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dest(s_dest), .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_dest(m_dest), .m_id(m_id), .m_last(m_last),
    .count(count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: the FIFO is just an ordered list of entries.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    dest;
    logic          last;
  } ent_t;

  ent_t q[$];

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      q.delete();
    end else begin
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push = s_valid && (q.size() < DEPTH);
      do_pop  = m_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.d    = s_data;
        e.dest = s_dest;
        e.last = s_last;
        q.push_back(e);
      end
    end
  end

  // Every cycle, compare all outputs against the model on the falling edge.
  always @(negedge aclk) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("s_ready", 32'(s_ready), 32'(!areset && (q.size() < DEPTH)));
    chk("m_valid", 32'(m_valid), 32'(q.size() > 0));
    chk("m_id", 32'(m_id), 32'd0);
    if (q.size() > 0) begin
      chk("m_data", 32'(m_data), 32'(q[0].d));
      chk("m_dest", 32'(m_dest), 32'(q[0].dest));
      chk("m_last", 32'(m_last), 32'(q[0].last));
    end
  end

  initial begin
    logic [7:0] exp_pop [5];
    logic [2:0] exp_cnt [5];
    exp_pop = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};

    areset = 1'b1; s_valid = 0; s_data = 0; s_dest = 0; s_id = 0; s_last = 0; m_ready = 0;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    step(); step();
    areset = 1'b0;
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 1);

    // Fill to full with the downstream stalled; fifth beat must be held off.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = 8'hA1 + 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    s_data = 8'hA5;
    step();
    chk("full_count", 32'(count), 4);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_head", 32'(m_data), 32'hA1);

    // Drain; A5 is accepted on the edge after the first pop.
    m_ready = 1;
    for (int j = 0; j < 5; j++) begin
      chk("drain_data", 32'(m_data), 32'(exp_pop[j]));
      chk("drain_valid", 32'(m_valid), 1);
      step();
      if (j == 1) s_valid = 0;
      chk("drain_count", 32'(count), 32'(exp_cnt[j]));
    end

    // Single beat through an empty FIFO with the downstream ready.
    s_valid = 1; s_data = 8'h55;
    chk("ft_before", 32'(m_valid), 0);
    step();
    s_valid = 0;
    chk("ft_valid", 32'(m_valid), 1);
    chk("ft_data", 32'(m_data), 32'h55);
    step();
    chk("ft_count", 32'(count), 0);
    chk("ft_empty", 32'(m_valid), 0);

    // Streaming with one preloaded entry: occupancy stays at one.
    m_ready = 0; s_valid = 1; s_data = 8'h10;
    step();
    m_ready = 1;
    for (int k = 0; k < 10; k++) begin
      s_data = 8'h11 + 8'(k);
      step();
      chk("stream_count", 32'(count), 1);
    end
    s_valid = 0;
    step();
    chk("stream_drain", 32'(count), 0);

    // Three-beat packet, reset after the first pop discards the rest.
    m_ready = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = 8'hB0 + 8'(k); s_dest = 2'd1; s_last = (k == 2);
      step();
    end
    s_valid = 0; s_last = 0; s_dest = 0;
    m_ready = 1;
    step();
    m_ready = 0;
    chk("pkt_head", 32'(m_data), 32'hB1);
    chk("pkt_dest", 32'(m_dest), 1);
    chk("pkt_count", 32'(count), 2);
    #2 areset = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_count", 32'(count), 0);
    step(); step();
    areset = 1'b0;
    #1;
    chk("rel_s_ready", 32'(s_ready), 1);
    chk("rel_m_valid", 32'(m_valid), 0);
    m_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_stale", 32'(m_valid), 0);
    end

    // Randomized traffic with toggling id; the model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) != 0) ? ((k / 200) % 2 == 0) : 1'b1;
      if ((k / 200) % 3 == 2) m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      s_dest  = 2'($urandom);
      s_id    = 2'($urandom);
      s_last  = 1'($urandom);
      step();
    end
    s_valid = 0; m_ready = 1;
    for (int k = 0; k < 6; k++) step();
    chk("final_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_slave_fifo.md
AXIS_SLAVE_FIFO -- requirements
Module: axis_slave_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning payload width.
REQ-002 The block SHALL have parameter DEST_WIDTH, default 1, meaning routing-tag width.
REQ-003 The block SHALL have parameter ID_WIDTH, default 1, meaning source-tag width.
REQ-004 The block SHALL have parameters HAS_DEST, HAS_ID and HAS_LAST, each default 0, meaning: when 1, that field is stored; when 0, that field is not stored.
REQ-005 The block SHALL have parameter DEPTH, default 16, meaning entries; DEPTH SHALL be a power of 2 and at least 2.
REQ-006 Ports (name, direction, width, meaning):
- aclk, in, 1, sole clock; all logic on the rising edge.
- areset, in, 1, asynchronous, active-high reset.
- s_valid, in, 1, upstream beat valid.
- s_ready, out, 1, FIFO can accept a beat.
- s_data, in, DATA_WIDTH, upstream payload.
- s_dest, in, DEST_WIDTH, upstream routing tag.
- s_id, in, ID_WIDTH, upstream source tag.
- s_last, in, 1, upstream end-of-packet.
- m_valid, out, 1, head entry valid; feeds one slave port of the stream switch.
- m_ready, in, 1, downstream switch accepts the head entry.
- m_data, out, DATA_WIDTH, head payload.
- m_dest, out, DEST_WIDTH, head routing tag.
- m_id, out, ID_WIDTH, head source tag.
- m_last, out, 1, head end-of-packet.
- count, out, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.

Function
REQ-007 A push SHALL occur on a rising edge where s_valid=1 and s_ready=1; a pop SHALL occur on a rising edge where m_valid=1 and m_ready=1.
REQ-008 s_ready SHALL be 1 exactly when count<DEPTH; s_ready SHALL NOT depend combinationally on m_ready.
REQ-009 m_valid SHALL be 1 exactly when count>0; m_data, m_dest, m_id and m_last SHALL present the oldest stored entry (first-word fall-through).
REQ-010 Latency: a beat pushed into an empty FIFO at edge N SHALL appear with m_valid=1 after edge N; no combinational path from s_* to m_* is permitted.
REQ-011 Order: entries SHALL leave in push order, and fields SHALL stay aligned per entry.
REQ-012 The write and read pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-013 count update per edge:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged, both performed.
- neither: unchanged.
REQ-014 Full (count=DEPTH): no push; a pop SHALL raise s_ready on the next cycle.
REQ-015 Empty (count=0): no pop regardless of m_ready; the m_* data outputs are don't-care except as REQ-016 requires.
REQ-016 When HAS_DEST=0, HAS_ID=0 or HAS_LAST=0, the matching m_dest, m_id or m_last SHALL be driven constant 0, and no storage SHALL be implemented for that field.
REQ-017 The state machine SHALL have the states EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH), with transitions:
- EMPTY to PARTIAL on push.
- PARTIAL to FULL on push-only when count=DEPTH-1.
- FULL to PARTIAL on pop.
- PARTIAL to EMPTY on pop-only when count=1.

Reset
REQ-018 While areset=1, independent of aclk:
- count=0 and both pointers=0.
- m_valid=0 and s_ready=0.
REQ-019 The first edge after areset falls SHALL see s_ready=1 and the FIFO EMPTY.
REQ-020 Assertion of areset mid-operation SHALL discard all stored entries, including a partially drained packet, and no beat SHALL be presented after reset until a new push.
REQ-021 Storage array contents SHALL NOT require reset.

Verification
REQ-022 DEPTH=4, m_ready=0; push D=0xA1..0xA4 on consecutive cycles -> count 1,2,3,4; s_ready=0 after 4th; 5th beat 0xA5 held and not accepted.
REQ-023 Continue REQ-022, set m_ready=1 -> pops 0xA1,0xA2,0xA3,0xA4 in order; 0xA5 accepted one cycle after first pop; count returns to 0 after 0xA5 drains.
REQ-024 Empty FIFO, s_valid=1 D=0x55 at edge N, m_ready=1 -> m_valid=0 before N, m_valid=1 with 0x55 after N, popped at N+1, count 0 after N+1.
REQ-025 Streaming with s_valid=m_ready=1 for 10 cycles after one preload, DEPTH=4 -> count constant at 1, pointers wrap at least twice, output order equals input order.
REQ-026 HAS_LAST=1, HAS_DEST=1; push 3-beat packet dest=1 last on beat 3, assert areset after first pop -> m_valid=0 and count=0 immediately; after release s_ready=1 and no stale beat appears.
REQ-027 HAS_ID=0, s_id toggling -> m_id constantly 0.
